imm_ext_pipe: RTL

- Registered, parametrised successor to the combinational immediate extender.
- Decodes the immediate from instruction bits [31:7] for XLEN=32 or XLEN=64 cores and sign- or zero-extends it to XLEN.
- Adds CSR zimm support, XLEN-aware shift-amount decoding and an illegal-shamt flag.
- Sits between decode and execute behind a valid/ready handshake with a 2-entry skid buffer, so the path is fully registered at 1 result/cycle.

---
 rtl/imm_ext_pipe.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/imm_ext_pipe.sv
// rtl/imm_ext_pipe.sv - registered immediate extender with 2-entry skid buffer
module imm_ext_pipe #(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 5,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [24:0]      instr_31_7_i,
  input  logic [2:0]       imm_src_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [XLEN-1:0]  imm_ext_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             illegal_o
);

  // Only RV32/RV64 datapaths exist; shift width follows XLEN.
  if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
    $error("imm_ext_pipe: XLEN must be 32 or 64");
  end
  if (SHAMT_W != $clog2(XLEN)) begin : g_bad_shamt
    $error("imm_ext_pipe: SHAMT_W is derived from XLEN and must not be overridden");
  end

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t            state, state_n;
  logic              in_xfer, out_xfer;
  logic              load_m_in, load_s, m_from_s;

  logic [24:0]       b;
  logic [XLEN-1:0]   dec_imm;
  logic              dec_ill;
  logic [63:0]       u_wide;

  logic [XLEN-1:0]   s_imm;
  logic [TAG_W-1:0]  s_tag;
  logic              s_ill;

  assign b = instr_31_7_i;
  // U-type is a 32-bit value; build it at 64 bits and keep the low XLEN.
  assign u_wide = {{32{b[24]}}, b[24:5], 12'b0};

  // Immediate format decode and extension to XLEN.
  always_comb begin
    dec_imm = '0;
    dec_ill = 1'b0;
    case (imm_src_i)
      3'b000: dec_imm = {{(XLEN-12){b[24]}}, b[24:13]};
      3'b001: dec_imm = {{(XLEN-12){b[24]}}, b[24:18], b[4:0]};
      3'b010: dec_imm = {{(XLEN-13){b[24]}}, b[24], b[0], b[23:18], b[4:1], 1'b0};
      3'b011: dec_imm = u_wide[XLEN-1:0];
      3'b100: dec_imm = {{(XLEN-21){b[24]}}, b[24], b[12:5], b[13], b[23:14], 1'b0};
      3'b101: begin
        dec_imm = {{(XLEN-SHAMT_W){1'b0}}, b[SHAMT_W+12:13]};
        // instr[25] set means shamt >= 32, which RV32 cannot encode.
        dec_ill = (XLEN == 32) && b[18];
      end
      3'b110: dec_imm = {{(XLEN-5){1'b0}}, b[12:8]};
      default: dec_imm = {{(XLEN-13){1'b0}}, b[24], b[0], b[23:18], b[4:1], 1'b0};
    endcase
  end

  assign in_xfer  = valid_i & ready_o;
  assign out_xfer = valid_o & ready_i;
  assign valid_o  = (state != EMPTY);

  // Occupancy state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= EMPTY;
      ready_o <= 1'b1;
    end else begin
      state   <= state_n;
      ready_o <= (state_n != TWO);
    end
  end

  // Next occupancy and which register loads from where.
  always_comb begin
    state_n   = state;
    load_m_in = 1'b0;
    load_s    = 1'b0;
    m_from_s  = 1'b0;
    case (state)
      EMPTY: begin
        if (in_xfer) begin
          load_m_in = 1'b1;
          state_n   = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          load_m_in = 1'b1;
        end else if (in_xfer) begin
          load_s  = 1'b1;
          state_n = TWO;
        end else if (out_xfer) begin
          state_n = EMPTY;
        end
      end
      TWO: begin
        if (out_xfer) begin
          m_from_s = 1'b1;
          state_n  = ONE;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  // Main (output) register: fresh item or promoted skid item.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      imm_ext_o <= '0;
      tag_o     <= '0;
      illegal_o <= 1'b0;
    end else if (load_m_in) begin
      imm_ext_o <= dec_imm;
      tag_o     <= tag_i;
      illegal_o <= dec_ill;
    end else if (m_from_s) begin
      imm_ext_o <= s_imm;
      tag_o     <= s_tag;
      illegal_o <= s_ill;
    end
  end

  // Skid register: catches the item accepted while main is stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_imm <= '0;
      s_tag <= '0;
      s_ill <= 1'b0;
    end else if (load_s) begin
      s_imm <= dec_imm;
      s_tag <= tag_i;
      s_ill <= dec_ill;
    end
  end

endmodule
